mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Byte-addressed, big-endian data/instruction memory with a wait-state handshake, sitting directly downstream of the control unit and the MAR/MDR pair. It accepts a memory request when the control unit raises MOV, performs a byte, halfword or word read/write after a programmable number of wait states, and signals completion on MOC, which the control unit tests through its condition mux. Read data is returned toward the MDR, zero- or sign-extended per SIG.

## Interface
- DEPTH, 512, memory size in bytes; must be a power of two; address is reduced modulo DEPTH.
- WAIT_CYCLES, 2, wait states between request acceptance and the access; legal range 0..15.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears controller state, not memory contents.
- MOV  in  1  memory operation valid (request) from control unit.
- RW  in  1  1 = read, 0 = write.
- DL  in  2  data length: 00 byte, 01 halfword, 10 word, 11 word (each doubleword half is a separate word request).
- SIG  in  1  reads only: 1 = sign-extend byte/halfword, 0 = zero-extend.
- addr  in  32  byte address from MAR; only log2(DEPTH) LSBs used.
- data_in  in  32  write data from MDR, right-justified.
- data_out  out  32  read data toward MDR.
- MOC  out  1  memory operation complete.
- align_err  out  1  last completed request was misaligned.

## Operation
- States: IDLE, WAIT, ACK.
- IDLE: MOC=0. If MOV=1 at a clock edge: latch addr, data_in, RW, DL, SIG; load counter with WAIT_CYCLES; clear align_err; go WAIT.
- WAIT: counter != 0 → decrement, stay. Counter == 0 → perform access, set MOC=1, go ACK.
- ACK: MOC=1 held while MOV=1. MOV=0 at an edge → MOC=0, go IDLE. No new request is accepted in ACK; MOV must drop first (full four-phase handshake).
- MOV dropping during WAIT is ignored; the latched access completes, MOC rises, then falls on the next edge with MOV=0.
- Inputs changing after acceptance have no effect; only latched values are used.
- Alignment: halfword requires a[0]=0; word requires a[1:0]=00. Misaligned request: no memory write, data_out unchanged, align_err=1, MOC still asserted normally so the control unit never stalls.
- Read, a = latched address mod DEPTH, big-endian:
  - Byte: mem[a], extended to 32 bits.
  - Halfword: {mem[a], mem[a+1]}, extended.
  - Word: {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
- Write: byte stores data_in[7:0]; halfword stores data_in[15:8]→mem[a], data_in[7:0]→mem[a+1]; word stores data_in[31:24]→mem[a] … data_in[7:0]→mem[a+3]. Writes leave data_out unchanged.
- Address wrap: addr ≥ DEPTH aliases modulo DEPTH. Byte offsets within an aligned access never cross DEPTH.
- data_out holds its value until the next successful read completes.

## Timing
- Reset values: state IDLE, MOC=0, data_out=0, align_err=0, counter=0. Memory contents are undefined at power-up and preserved across reset.
- Reset asserted mid-request (WAIT or ACK): immediate return to IDLE with MOC=0. A pending write that has not reached its access edge is discarded. A write performed before reset remains.
- Latency: if the accepting edge is edge 0, the access occurs and MOC rises at edge WAIT_CYCLES+1. With WAIT_CYCLES=0, MOC rises one edge after acceptance.
- MOC falls on the first edge where MOV=0 in ACK. The earliest next acceptance is the following edge.
- data_out and align_err update on the same edge that MOC rises.

## Test plan
- Reset then idle: reset=0 for 2 cycles, release, MOV=0 → MOC=0, data_out=0, align_err=0 for 10 cycles.
- Word write/read with WAIT_CYCLES=2: write 32'hDEADBEEF at addr 0x10, then read word at 0x10 → MOC rises exactly 3 edges after acceptance each time; data_out=32'hDEADBEEF; byte read 0x10 SIG=0 → 32'h000000DE.
- Extension: after the above, halfword read at 0x12 SIG=1 → 32'hFFFFBEEF; SIG=0 → 32'h0000BEEF; byte read 0x13 SIG=1 → 32'hFFFFFFEF.
- Misalignment: word write 32'h12345678 at 0x11 → MOC asserted, align_err=1; word read at 0x10 still returns 32'hDEADBEEF, align_err=0.
- Wrap-around and handshake: with DEPTH=512, byte write 8'hA5 at 0x205, then byte read at 0x005 → 32'h000000A5. Hold MOV=1 for 5 cycles in ACK → MOC stays 1, no second access; drop MOV → MOC=0 next edge.
- Reset mid-operation: word write 32'h0 at 0x10 and assert reset during WAIT → MOC=0 immediately. After release, read 0x10 → 32'hDEADBEEF (write discarded).

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte-addressed big-endian memory behind a MOV/MOC
// four-phase handshake. A request is latched on acceptance, waits a fixed
// number of cycles, then performs one byte/halfword/word access. A misaligned
// access is suppressed but still completes, so the control unit never stalls.
module mem_access_ctrl #(
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MOV,
    input  logic        RW,
    input  logic [1:0]  DL,
    input  logic        SIG,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        MOC,
    output logic        align_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10
    } state_t;

    // Halfwords need a[0]=0, words (DL=10/11) need a[1:0]=00.
    function automatic logic is_misaligned(input logic [1:0] dl, input logic [1:0] lsb);
        logic mis;
        case (dl)
            2'b00:   mis = 1'b0;
            2'b01:   mis = lsb[0];
            default: mis = (lsb != 2'b00);
        endcase
        return mis;
    endfunction

    // Memory contents are deliberately outside the reset domain.
    logic [7:0]    mem_r [DEPTH];

    state_t        state_r;
    logic [3:0]    cnt_r;
    logic [AW-1:0] addr_r;
    logic [31:0]   wdata_r;
    logic          rw_r;
    logic [1:0]    dl_r;
    logic          sig_r;
    logic [31:0]   data_out_r;
    logic          moc_r;
    logic          align_err_r;

    logic [AW-1:0] a1_s, a2_s, a3_s;
    logic [7:0]    b0_s, b1_s, b2_s, b3_s;
    logic [31:0]   rdata_s;
    logic          mis_s;
    logic          access_s;
    logic          do_write_s;
    logic          unused_s;

    // Only the low address bits select a location; the rest alias.
    assign unused_s = ^addr[31:AW];

    // Byte lanes of an aligned access never cross DEPTH, so AW-bit adds suffice.
    assign a1_s = addr_r + AW'(1);
    assign a2_s = addr_r + AW'(2);
    assign a3_s = addr_r + AW'(3);
    assign b0_s = mem_r[addr_r];
    assign b1_s = mem_r[a1_s];
    assign b2_s = mem_r[a2_s];
    assign b3_s = mem_r[a3_s];

    assign mis_s      = is_misaligned(dl_r, addr_r[1:0]);
    assign access_s   = (state_r == ST_WAIT) && (cnt_r == 4'd0);
    assign do_write_s = access_s && !rw_r && !mis_s;

    // Assemble big-endian read data and apply zero/sign extension.
    always_comb begin
        rdata_s = 32'h0000_0000;
        case (dl_r)
            2'b00:   rdata_s = sig_r ? {{24{b0_s[7]}}, b0_s} : {24'h00_0000, b0_s};
            2'b01:   rdata_s = sig_r ? {{16{b0_s[7]}}, b0_s, b1_s} : {16'h0000, b0_s, b1_s};
            default: rdata_s = {b0_s, b1_s, b2_s, b3_s};
        endcase
    end

    // Store bytes big-endian on the access edge of an aligned write.
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            case (dl_r)
                2'b00: mem_r[addr_r] <= wdata_r[7:0];
                2'b01: begin
                    mem_r[addr_r] <= wdata_r[15:8];
                    mem_r[a1_s]   <= wdata_r[7:0];
                end
                default: begin
                    mem_r[addr_r] <= wdata_r[31:24];
                    mem_r[a1_s]   <= wdata_r[23:16];
                    mem_r[a2_s]   <= wdata_r[15:8];
                    mem_r[a3_s]   <= wdata_r[7:0];
                end
            endcase
        end
    end

    // Handshake FSM: latch request, count wait states, access, hold MOC until MOV drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            addr_r      <= '0;
            wdata_r     <= 32'h0000_0000;
            rw_r        <= 1'b0;
            dl_r        <= 2'b00;
            sig_r       <= 1'b0;
            data_out_r  <= 32'h0000_0000;
            moc_r       <= 1'b0;
            align_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    moc_r <= 1'b0;
                    if (MOV) begin
                        addr_r      <= addr[AW-1:0];
                        wdata_r     <= data_in;
                        rw_r        <= RW;
                        dl_r        <= DL;
                        sig_r       <= SIG;
                        cnt_r       <= 4'(WAIT_CYCLES);
                        align_err_r <= 1'b0;
                        state_r     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        moc_r       <= 1'b1;
                        align_err_r <= mis_s;
                        if (rw_r && !mis_s) begin
                            data_out_r <= rdata_s;
                        end
                        state_r <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!MOV) begin
                        moc_r   <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    moc_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out  = data_out_r;
    assign MOC       = moc_r;
    assign align_err = align_err_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: table of requests with expected results pushed to
// a scoreboard queue when driven and popped when MOC rises, plus hand-written
// reset, early-drop and mid-request reset sequences.
module tb_mem_access_ctrl;

    localparam int DEPTH = 512;
    localparam int WAITC = 2;

    logic        clk;
    logic        reset;
    logic        MOV;
    logic        RW;
    logic [1:0]  DL;
    logic        SIG;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        MOC;
    logic        align_err;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .reset(reset), .MOV(MOV), .RW(RW), .DL(DL), .SIG(SIG),
        .addr(addr), .data_in(data_in), .data_out(data_out), .MOC(MOC),
        .align_err(align_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [1:0]  dl;
        logic        sig;
        logic [31:0] a;
        logic [31:0] wdata;
        logic [31:0] exp_dout;
        logic        exp_err;
        int          hold;
        logic        early;
    } vec_t;

    vec_t vecs[16];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rw, input logic [1:0] dl, input logic sig,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] ed, input logic ee,
                                input int hold, input logic early);
        vec_t v;
        v.rw = rw; v.dl = dl; v.sig = sig; v.a = a; v.wdata = wd;
        v.exp_dout = ed; v.exp_err = ee; v.hold = hold; v.early = early;
        return v;
    endfunction

    // Called #1 after a rising edge with the DUT idle and MOV low.
    task automatic run_req(input vec_t v);
        int   n;
        vec_t e;
        MOV = 1'b1; RW = v.rw; DL = v.dl; SIG = v.sig; addr = v.a; data_in = v.wdata;
        sb.push_back(v);
        @(posedge clk); #1;
        // Scramble inputs: only latched values may matter from here on.
        addr = $urandom; data_in = $urandom; DL = ~v.dl; SIG = ~v.sig;
        if (v.early) MOV = 1'b0;
        n = 0;
        while (MOC !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(WAITC + 1));
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("data_out", data_out, e.exp_dout);
            chk("align_err", {31'd0, align_err}, {31'd0, e.exp_err});
        end
        if (v.early) begin
            @(posedge clk); #1;
            chk("moc_fall_early", {31'd0, MOC}, 32'd0);
        end else begin
            for (int h = 0; h < v.hold; h++) begin
                @(posedge clk); #1;
                chk("moc_hold", {31'd0, MOC}, 32'd1);
                chk("dout_hold", data_out, v.exp_dout);
            end
            MOV = 1'b0;
            @(posedge clk); #1;
            chk("moc_fall", {31'd0, MOC}, 32'd0);
        end
        RW = 1'b0; DL = 2'b00; SIG = 1'b0;
    endtask

    initial begin
        int n;
        //            rw    dl     sig   addr          wdata          exp_dout       err   hold early
        vecs[0]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0, 1'b0);
        vecs[1]  = mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        vecs[2]  = mk(1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_00DE, 1'b0, 0, 1'b0);
        vecs[3]  = mk(1'b1, 2'b01, 1'b1, 32'h0000_0012, 32'h0,         32'hFFFF_BEEF, 1'b0, 0, 1'b0);
        vecs[4]  = mk(1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_BEEF, 1'b0, 0, 1'b0);
        vecs[5]  = mk(1'b1, 2'b00, 1'b1, 32'h0000_0013, 32'h0,         32'hFFFF_FFEF, 1'b0, 0, 1'b0);
        vecs[6]  = mk(1'b0, 2'b10, 1'b0, 32'h0000_0011, 32'h1234_5678, 32'hFFFF_FFEF, 1'b1, 0, 1'b0);
        vecs[7]  = mk(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        vecs[8]  = mk(1'b0, 2'b00, 1'b0, 32'h0000_0205, 32'h0000_00A5, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        vecs[9]  = mk(1'b1, 2'b00, 1'b0, 32'h0000_0005, 32'h0,         32'h0000_00A5, 1'b0, 5, 1'b0);
        vecs[10] = mk(1'b1, 2'b01, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_00A5, 1'b1, 0, 1'b0);
        vecs[11] = mk(1'b1, 2'b00, 1'b1, 32'h0000_0011, 32'h0,         32'hFFFF_FFAD, 1'b0, 0, 1'b1);
        vecs[12] = mk(1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h1234_ABCD, 32'hFFFF_FFAD, 1'b0, 0, 1'b0);
        vecs[13] = mk(1'b1, 2'b01, 1'b0, 32'h0000_0020, 32'h0,         32'h0000_ABCD, 1'b0, 0, 1'b0);
        vecs[14] = mk(1'b0, 2'b11, 1'b0, 32'h0000_01FC, 32'h0102_0304, 32'h0000_ABCD, 1'b0, 0, 1'b1);
        vecs[15] = mk(1'b1, 2'b11, 1'b0, 32'h0000_03FC, 32'h0,         32'h0102_0304, 1'b0, 0, 1'b0);

        reset = 1'b0; MOV = 1'b0; RW = 1'b0; DL = 2'b00; SIG = 1'b0;
        addr = 32'h0; data_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_moc", {31'd0, MOC}, 32'd0);
        chk("rst_dout", data_out, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_moc", {31'd0, MOC}, 32'd0);
            chk("idle_dout", data_out, 32'd0);
            chk("idle_err", {31'd0, align_err}, 32'd0);
        end

        for (int i = 0; i < 16; i++) run_req(vecs[i]);

        // Reset during WAIT: pending write of zero must be discarded.
        MOV = 1'b1; RW = 1'b0; DL = 2'b10; addr = 32'h10; data_in = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; #1;
        chk("rst_wait_moc", {31'd0, MOC}, 32'd0);
        chk("rst_wait_dout", data_out, 32'd0);
        MOV = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_req(mk(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0));

        // Reset during ACK: MOC and data_out drop immediately.
        MOV = 1'b1; RW = 1'b1; DL = 2'b10; addr = 32'h10;
        n = 0;
        while (MOC !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ack_reached", {31'd0, MOC}, 32'd1);
        reset = 1'b0; #1;
        chk("rst_ack_moc", {31'd0, MOC}, 32'd0);
        chk("rst_ack_dout", data_out, 32'd0);
        MOV = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {31'd0, MOC}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
